// File: rtl/drp_scan_sequencer.sv
// drp_scan_sequencer: walks a DRP address window, captures one clean word per address, flags changes and watches for stalls
module drp_scan_sequencer #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 8,
   parameter int TIMEOUT  = 64,
   localparam int IDX_W   = $clog2(NUM_REGS),
   localparam int CNT_W   = $clog2(NUM_REGS + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              scan_en,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  scan_len,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   input  logic              rd_valid,
   input  logic [IDX_W-1:0]  tbl_idx,
   output logic [DATA_W-1:0] tbl_data,
   output logic              tbl_changed,
   input  logic              chg_clr,
   input  logic              err_clr,
   output logic              scan_busy,
   output logic              scan_done,
   output logic              timeout_err
);
   localparam int WD_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, NEXT} state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [CNT_W-1:0]    len_q, len_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic [WD_W-1:0]     wd_q, wd_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   tbl_q [NUM_REGS];
   logic [DATA_W-1:0]   tbl_d [NUM_REGS];
   logic [NUM_REGS-1:0] chg_q, chg_d;
   logic [NUM_REGS-1:0] seen_q, seen_d;
   logic [DATA_W-1:0]   tbl_data_q;
   logic                tbl_chg_q;
   logic [CNT_W-1:0]    len_clamp;
   logic                start_ok;
   logic                last;

   assign len_clamp   = scan_len > CNT_W'(NUM_REGS) ? CNT_W'(NUM_REGS) : scan_len;
   assign start_ok    = scan_en && scan_len != '0;
   assign last        = CNT_W'(idx_q) == len_q - CNT_W'(1);
   assign rd_addr     = rd_addr_q;
   assign tbl_data    = tbl_data_q;
   assign tbl_changed = tbl_chg_q;
   assign scan_busy   = state_q != IDLE;
   assign scan_done   = state_q == NEXT && last;
   assign timeout_err = err_q;

   // Scan FSM: address stepping, stale-word discard, capture with change detect, watchdog
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      base_d    = base_q;
      len_d     = len_q;
      rd_addr_d = rd_addr_q;
      wd_d      = wd_q;
      err_d     = err_clr ? 1'b0 : err_q;
      chg_d     = chg_clr ? '0 : chg_q;
      seen_d    = seen_q;
      tbl_d     = tbl_q;
      case (state_q)
         IDLE: if (start_ok) begin
            base_d    = base_addr;
            len_d     = len_clamp;
            idx_d     = '0;
            rd_addr_d = base_addr;
            wd_d      = '0;
            state_d   = SETTLE;
         end
         SETTLE, CAPTURE: begin
            wd_d = wd_q + 1'b1;
            if (rd_valid) begin
               wd_d    = '0;
               state_d = state_q == SETTLE ? CAPTURE : NEXT;
               if (state_q == CAPTURE) begin
                  tbl_d[idx_q]  = rd_data;
                  seen_d[idx_q] = 1'b1;
                  if (seen_q[idx_q] && rd_data != tbl_q[idx_q]) chg_d[idx_q] = 1'b1;
               end
            end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
               wd_d    = '0;
               err_d   = 1'b1;
               state_d = NEXT;
            end
         end
         NEXT: begin
            idx_d   = '0;
            wd_d    = '0;
            state_d = IDLE;
            if (last && start_ok) begin
               base_d    = base_addr;
               len_d     = len_clamp;
               rd_addr_d = base_addr;
               state_d   = SETTLE;
            end else if (!last && scan_en) begin
               idx_d     = idx_q + 1'b1;
               rd_addr_d = base_q + ADDR_W'(idx_q) + ADDR_W'(1);
               state_d   = SETTLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, table and registered readback with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         base_q     <= '0;
         len_q      <= '0;
         rd_addr_q  <= '0;
         wd_q       <= '0;
         err_q      <= 1'b0;
         tbl_q      <= '{default: '0};
         chg_q      <= '0;
         seen_q     <= '0;
         tbl_data_q <= '0;
         tbl_chg_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         base_q     <= base_d;
         len_q      <= len_d;
         rd_addr_q  <= rd_addr_d;
         wd_q       <= wd_d;
         err_q      <= err_d;
         tbl_q      <= tbl_d;
         chg_q      <= chg_d;
         seen_q     <= seen_d;
         tbl_data_q <= tbl_q[tbl_idx];
         tbl_chg_q  <= chg_q[tbl_idx];
      end
   end
endmodule

// File: tb/tb_drp_scan_sequencer.sv
// tb_drp_scan_sequencer: drives a 4-cycle read-engine model and checks the sequencer against a scan-level model
module tb_drp_scan_sequencer;
   localparam int NUM_REGS = 8;
   localparam int TIMEOUT  = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        scan_en = 1'b0;
   logic [7:0]  base_addr = '0;
   logic [3:0]  scan_len = '0;
   logic [7:0]  rd_addr;
   logic [15:0] rd_data = '0;
   logic        rd_valid = 1'b0;
   logic [2:0]  tbl_idx = '0;
   logic [15:0] tbl_data;
   logic        tbl_changed;
   logic        chg_clr = 1'b0;
   logic        err_clr = 1'b0;
   logic        scan_busy;
   logic        scan_done;
   logic        timeout_err;

   int checks = 0;
   int passes = 0;

   drp_scan_sequencer dut (
      .clk(clk), .rst(rst), .scan_en(scan_en), .base_addr(base_addr), .scan_len(scan_len),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .tbl_idx(tbl_idx),
      .tbl_data(tbl_data), .tbl_changed(tbl_changed), .chg_clr(chg_clr), .err_clr(err_clr),
      .scan_busy(scan_busy), .scan_done(scan_done), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Read engine: one read in flight, result 4 cycles after the address was latched
   logic [7:0] lat_addr = '0, prev_addr = '0;
   logic       dead_pend = 1'b0, stale_en = 1'b1, ovr_en = 1'b0, mute_en = 1'b0;
   int         rcnt = 0;
   initial forever begin
      @(negedge clk);
      rd_valid = 1'b0;
      if (rd_addr != prev_addr) dead_pend = 1'b1;
      prev_addr = rd_addr;
      rcnt++;
      if (rcnt == 4) begin
         rcnt     = 0;
         rd_data  = (stale_en && dead_pend) ? 16'hDEAD :
                    (ovr_en && lat_addr == 8'h11) ? 16'h1234 : {8'h00, lat_addr ^ 8'hA5};
         rd_valid = !(mute_en && rd_addr == 8'h12);
         dead_pend = 1'b0;
         lat_addr  = rd_addr;
      end
   end

   // Scan-level model: address list per scan, discard-then-capture per entry, timeout skip
   logic [15:0] m_tbl [NUM_REGS];
   logic [7:0]  m_chg, m_seen, m_addr;
   logic [7:0]  m_list [$];
   int          m_ph, m_i, m_n, m_wd;
   logic        m_err, m_done, m_rb_chg;
   logic [15:0] m_rb_data;

   task automatic m_reset();
      foreach (m_tbl[k]) m_tbl[k] = '0;
      m_chg = '0; m_seen = '0; m_addr = '0; m_ph = 0; m_i = 0; m_n = 1; m_wd = 0;
      m_err = 1'b0; m_done = 1'b0; m_rb_data = '0; m_rb_chg = 1'b0;
   endtask

   task automatic m_start();
      m_n = scan_len > NUM_REGS ? NUM_REGS : int'(scan_len);
      m_list.delete();
      for (int k = 0; k < m_n; k++) m_list.push_back(8'(int'(base_addr) + k));
      m_i = 0; m_addr = m_list[0]; m_ph = 1; m_wd = 0;
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) m_reset();
         else begin
            m_rb_data = m_tbl[tbl_idx];
            m_rb_chg  = m_chg[tbl_idx];
            if (chg_clr) m_chg = '0;
            if (err_clr) m_err = 1'b0;
            case (m_ph)
               0: if (scan_en && scan_len != 0) m_start();
               1, 2: if (rd_valid) begin
                  if (m_ph == 2) begin
                     if (m_seen[m_i] && m_tbl[m_i] != rd_data) m_chg[m_i] = 1'b1;
                     m_tbl[m_i] = rd_data; m_seen[m_i] = 1'b1; m_ph = 3;
                  end else m_ph = 2;
                  m_wd = 0;
               end else begin
                  m_wd++;
                  if (m_wd == TIMEOUT) begin m_err = 1'b1; m_ph = 3; end
               end
               default: if (m_i == m_n - 1) begin
                  if (scan_en && scan_len != 0) m_start();
                  else begin m_ph = 0; m_i = 0; end
               end else if (scan_en) begin
                  m_i++; m_addr = m_list[m_i]; m_ph = 1; m_wd = 0;
               end else begin m_ph = 0; m_i = 0; end
            endcase
            m_done = m_ph == 3 && m_i == m_n - 1;
         end
      end
   end

   // Cycle compare against the model
   initial forever begin
      @(negedge clk);
      chk("rd_addr", rd_addr, m_addr);
      chk("scan_busy", scan_busy, m_ph != 0);
      chk("scan_done", scan_done, m_done);
      chk("timeout_err", timeout_err, m_err);
      chk("tbl_data", tbl_data, m_rb_data);
      chk("tbl_changed", tbl_changed, m_rb_chg);
   end

   // Observed address changes and completed scans
   logic [7:0] addr_log [$];
   logic [7:0] mon_prev = '0;
   int         done_cnt = 0;
   initial forever begin
      @(negedge clk);
      if (rd_addr != mon_prev) addr_log.push_back(rd_addr);
      mon_prev = rd_addr;
      if (scan_done) done_cnt++;
   end

   function automatic logic cond(int sel, logic [7:0] a);
      return sel == 0 ? scan_done : sel == 1 ? !scan_busy : sel == 2 ? timeout_err : rd_addr == a;
   endfunction

   task automatic wait_for(int sel, logic [7:0] a, int max);
      int n = 0;
      do begin @(negedge clk); n++; end while (!cond(sel, a) && n < max);
      chk($sformatf("wait_sel%0d", sel), cond(sel, a), 1);
   endtask

   task automatic rb(int i, logic [15:0] d, logic c);
      tbl_idx = 3'(i);
      @(negedge clk);
      chk($sformatf("rb_data[%0d]", i), tbl_data, d);
      chk($sformatf("rb_changed[%0d]", i), tbl_changed, c);
   endtask

   logic [7:0] exp_wrap [8] = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};

   initial begin
      int n, d0;
      repeat (3) @(negedge clk);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_busy", scan_busy, 0);
      chk("rst_done", scan_done, 0);
      chk("rst_err", timeout_err, 0);
      chk("rst_tbl_data", tbl_data, 0);
      rst = 1'b0;
      base_addr = 8'h10; scan_len = 0; scan_en = 1'b1;
      repeat (5) @(negedge clk);
      chk("len0_idle", scan_busy, 0);
      addr_log.delete();
      scan_len = 3;
      wait_for(0, 0, 200);
      scan_en = 1'b0;
      wait_for(1, 0, 50);
      @(negedge clk);
      chk("scan1_naddr", addr_log.size(), 3);
      for (int k = 0; k < 3; k++) chk($sformatf("scan1_addr%0d", k), addr_log[k], 8'h10 + 8'(k));
      chk("scan1_done_cnt", done_cnt, 1);
      rb(0, 16'h00B5, 0); rb(1, 16'h00B4, 0); rb(2, 16'h00B7, 0);
      ovr_en = 1'b1; scan_en = 1'b1;
      wait_for(0, 0, 200);
      scan_en = 1'b0;
      wait_for(1, 0, 50);
      @(negedge clk);
      chk("scan2_done_cnt", done_cnt, 2);
      rb(0, 16'h00B5, 0); rb(1, 16'h1234, 1); rb(2, 16'h00B7, 0);
      ovr_en = 1'b0;
      chg_clr = 1'b1; @(negedge clk); chg_clr = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tbl_idx = 3'(k); @(negedge clk);
         chk($sformatf("chg_clr[%0d]", k), tbl_changed, 0);
      end
      mute_en = 1'b1; scan_en = 1'b1;
      wait_for(2, 0, 400);
      mute_en = 1'b0;
      @(negedge clk);
      chk("timeout_restart_addr", rd_addr, 8'h10);
      rb(2, 16'h00B7, 0);
      wait_for(0, 0, 200);
      scan_en = 1'b0;
      wait_for(1, 0, 50);
      chk("err_sticky", timeout_err, 1);
      err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
      @(negedge clk);
      chk("err_cleared", timeout_err, 0);
      addr_log.delete();
      base_addr = 8'hFE; scan_len = 15; scan_en = 1'b1;
      wait_for(0, 0, 400);
      scan_en = 1'b0;
      wait_for(1, 0, 50);
      chk("wrap_naddr", addr_log.size(), 8);
      for (int k = 0; k < 8; k++) chk($sformatf("wrap_addr%0d", k), addr_log[k], exp_wrap[k]);
      rb(7, 16'h00A0, 0);
      addr_log.delete();
      d0 = done_cnt;
      base_addr = 8'h20; scan_len = 4; scan_en = 1'b1;
      wait_for(3, 8'h21, 100);
      scan_en = 1'b0;
      wait_for(1, 0, 100);
      @(negedge clk);
      chk("drop_naddr", addr_log.size(), 2);
      chk("drop_addr1", addr_log[1], 8'h21);
      chk("drop_no_done", done_cnt, d0);
      rb(1, 16'h0084, 1);
      base_addr = 8'h30; scan_len = 2; scan_en = 1'b1;
      wait_for(3, 8'h30, 50);
      n = 0;
      do begin @(posedge clk); n++; end while (!rd_valid && n < 20);
      chk("discard_seen", rd_valid, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_rd_addr", rd_addr, 0);
      chk("arst_busy", scan_busy, 0);
      chk("arst_done", scan_done, 0);
      chk("arst_err", timeout_err, 0);
      chk("arst_tbl_data", tbl_data, 0);
      chk("arst_tbl_changed", tbl_changed, 0);
      @(negedge clk);
      rst = 1'b0;
      base_addr = 8'h40; scan_len = 2;
      wait_for(0, 0, 200);
      scan_en = 1'b0;
      wait_for(1, 0, 50);
      rb(0, 16'h00E5, 0); rb(1, 16'h00E4, 0); rb(5, 16'h0000, 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish before 200000");
      $fatal(1);
   end
endmodule
